imem_loader: RTL and testbench

Boot-time instruction loader and instruction memory for the ONC-16 pipelined CPU.
- Accepts a length-prefixed byte stream over a valid/ready handshake and assembles it into INST_W-bit instruction words.
- Writes the words into an internal instruction RAM while holding the CPU in reset.
- Releases the CPU once the image is complete.
- Sits directly upstream of the CPU: its read port drives the CPU's instruction-memory input, and its control outputs drive the CPU's n_rst and en.

---
 rtl/imem_loader.sv | 151 +++++++++++++++
 tb/tb_imem_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction loader: assembles a length-prefixed big-endian byte stream
// into instruction words, writes them to an internal RAM and releases the CPU when done.
//
// Stream handshake: a byte moves on a rising edge where in_valid && in_ready;
// in_data is sampled on that edge, and a bubble on in_valid holds all state.
module imem_loader #(
  parameter int INST_W = 16,
  parameter int AW     = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic [15:0]       imem_addr,
  output logic [INST_W-1:0] imem_dout,
  output logic              cpu_n_rst,
  output logic              cpu_en,
  output logic [15:0]       loaded_words,
  output logic              overflow,
  output logic [1:0]        dbg_state
);

  localparam int BPW   = INST_W / 8;
  localparam int CW    = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {S_LEN_HI = 2'd0, S_LEN_LO = 2'd1, S_DATA = 2'd2, S_RUN = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [INST_W-1:0] asm_q, asm_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       words_q, words_d;
  logic              ovf_q, ovf_d;
  logic              run_q;

  logic              accept;
  logic              last_byte;
  logic              final_word;
  logic              wr_in_range;
  logic              mem_we;
  logic [INST_W-1:0] word_full;

  logic [INST_W-1:0] mem [DEPTH];

  // Shared datapath decodes; the shift lets earlier bytes climb toward the MSBs.
  always_comb begin
    accept      = in_valid && in_ready;
    last_byte   = (cnt_q == CW'(BPW - 1));
    word_full   = (asm_q << 8) | INST_W'(in_data);
    final_word  = (({1'b0, words_q} + 17'd1) == {1'b0, len_q});
    wr_in_range = ({1'b0, words_q} < 17'(DEPTH));
    mem_we      = accept && (state_q == S_DATA) && last_byte && wr_in_range;
  end

  // State register
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= S_LEN_HI;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= (state_d == S_RUN);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (load_start) begin
      state_d = S_LEN_HI;
    end else if (accept) begin
      case (state_q)
        S_LEN_HI: state_d = S_LEN_LO;
        S_LEN_LO: state_d = ({len_q[15:8], in_data} == 16'd0) ? S_RUN : S_DATA;
        S_DATA:   if (last_byte && final_word) state_d = S_RUN;
        default:  state_d = state_q;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state_q != S_RUN) && !load_start;
    dbg_state = state_q;
    cpu_n_rst = run_q;
    cpu_en    = run_q;
  end

  always_comb begin
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    len_d   = len_q;
    words_d = words_q;
    ovf_d   = ovf_q;
    if (load_start) begin
      cnt_d   = '0;
      asm_d   = '0;
      words_d = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      case (state_q)
        S_LEN_HI: len_d[15:8] = in_data;
        S_LEN_LO: len_d[7:0]  = in_data;
        S_DATA: begin
          asm_d = word_full;
          cnt_d = last_byte ? '0 : cnt_q + 1'b1;
          if (last_byte) begin
            // Out-of-range words still count so the index keeps tracking the stream.
            words_d = (words_q == 16'hFFFF) ? words_q : words_q + 16'd1;
            if (!wr_in_range) ovf_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      asm_q   <= '0;
      len_q   <= '0;
      words_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      len_q   <= len_d;
      words_q <= words_d;
      ovf_q   <= ovf_d;
    end
  end

  // RAM has no reset; contents survive rst and load_start.
  always_ff @(posedge clock) begin
    if (mem_we) mem[words_q[AW-1:0]] <= word_full;
  end

  always_comb begin
    imem_dout = '0;
    if ((state_q == S_RUN) && ({1'b0, imem_addr} < 17'(DEPTH)))
      imem_dout = mem[imem_addr[AW-1:0]];
  end

  assign loaded_words = words_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: one task per scenario with inline comparisons.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [15:0] imem_addr = 16'h0000;
  logic [15:0] imem_dout;
  logic        cpu_n_rst;
  logic        cpu_en;
  logic [15:0] loaded_words;
  logic        overflow;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  imem_loader #(.INST_W(16), .AW(8)) dut (
    .clock(clock), .rst(rst), .load_start(load_start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_addr(imem_addr), .imem_dout(imem_dout),
    .cpu_n_rst(cpu_n_rst), .cpu_en(cpu_en),
    .loaded_words(loaded_words), .overflow(overflow), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drivers
  task automatic send_byte(input logic [7:0] b, input int gap, output logic rdy_seen);
    int n;
    for (int i = 0; i < gap; i++) @(negedge clock);
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = b;
    rdy_seen = in_ready;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_byte_timeout byte=%h in_ready stuck at 0, required 1", b);
    end
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic pulse_load();
    @(negedge clock);
    load_start = 1'b1;
    @(posedge clock);
    #1 load_start = 1'b0;
  endtask

  task automatic read_mem(input logic [15:0] a, output logic [15:0] d);
    imem_addr = a;
    #1 d = imem_dout;
  endtask

  // Scenarios
  task automatic test_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (cpu_n_rst !== 1'b0 || cpu_en !== 1'b0) begin failures++; $display("FAIL reset_cpu got=%b%b exp=00", cpu_n_rst, cpu_en); end
    checks++; if (loaded_words !== 16'h0 || overflow !== 1'b0) begin failures++; $display("FAIL reset_count got=%h/%b exp=0000/0", loaded_words, overflow); end
    checks++; if (imem_dout !== 16'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0000", imem_dout); end
    rst = 1'b0;
    #1;
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_basic();
    logic [7:0]  bytes [6];
    logic [15:0] d;
    logic        r;
    bytes = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    for (int i = 0; i < 5; i++) send_byte(bytes[i], 0, r);
    imem_addr = 16'h0000;
    #1;
    checks++; if (cpu_n_rst !== 1'b0 || imem_dout !== 16'h0) begin failures++; $display("FAIL basic_pre_release got n_rst=%b dout=%h exp=0/0000", cpu_n_rst, imem_dout); end
    send_byte(bytes[5], 0, r);
    checks++; if (cpu_n_rst !== 1'b1 || cpu_en !== 1'b1) begin failures++; $display("FAIL basic_release got=%b%b exp=11", cpu_n_rst, cpu_en); end
    checks++; if (loaded_words !== 16'd2) begin failures++; $display("FAIL basic_words got=%0d exp=2", loaded_words); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_run_ready got=%b exp=0", in_ready); end
    read_mem(16'd0, d);
    checks++; if (d !== 16'h1234) begin failures++; $display("FAIL basic_mem0 got=%h exp=1234", d); end
    read_mem(16'd1, d);
    checks++; if (d !== 16'hABCD) begin failures++; $display("FAIL basic_mem1 got=%h exp=abcd", d); end
    read_mem(16'h0100, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL basic_out_of_range got=%h exp=0000", d); end
  endtask

  task automatic test_zero_len();
    logic r;
    pulse_load();
    checks++; if (cpu_n_rst !== 1'b0 || loaded_words !== 16'd0) begin failures++; $display("FAIL zero_restart got n_rst=%b words=%0d exp=0/0", cpu_n_rst, loaded_words); end
    send_byte(8'h00, 0, r);
    checks++; if (cpu_n_rst !== 1'b0) begin failures++; $display("FAIL zero_after_hi got=%b exp=0", cpu_n_rst); end
    send_byte(8'h00, 0, r);
    checks++; if (cpu_n_rst !== 1'b1 || cpu_en !== 1'b1) begin failures++; $display("FAIL zero_release got=%b%b exp=11", cpu_n_rst, cpu_en); end
    checks++; if (loaded_words !== 16'd0 || overflow !== 1'b0) begin failures++; $display("FAIL zero_count got=%0d/%b exp=0/0", loaded_words, overflow); end
  endtask

  task automatic test_overflow();
    logic [15:0] w;
    logic [15:0] d;
    logic        r;
    pulse_load();
    send_byte(8'h01, 0, r);
    send_byte(8'h01, 0, r);
    for (int i = 0; i < 256; i++) begin
      w = 16'(i * 3 + 7);
      send_byte(w[15:8], 0, r);
      send_byte(w[7:0], 0, r);
    end
    checks++; if (overflow !== 1'b0 || loaded_words !== 16'h0100 || cpu_n_rst !== 1'b0) begin failures++; $display("FAIL ovf_at_256 got ovf=%b words=%h n_rst=%b exp=0/0100/0", overflow, loaded_words, cpu_n_rst); end
    send_byte(8'h03, 0, r);
    send_byte(8'h07, 0, r);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (loaded_words !== 16'h0101 || cpu_n_rst !== 1'b1) begin failures++; $display("FAIL ovf_run got words=%h n_rst=%b exp=0101/1", loaded_words, cpu_n_rst); end
    read_mem(16'd0, d);
    checks++; if (d !== 16'h0007) begin failures++; $display("FAIL ovf_mem0 got=%h exp=0007", d); end
    read_mem(16'd128, d);
    checks++; if (d !== 16'h0187) begin failures++; $display("FAIL ovf_mem128 got=%h exp=0187", d); end
    read_mem(16'd255, d);
    checks++; if (d !== 16'h0304) begin failures++; $display("FAIL ovf_mem255 got=%h exp=0304", d); end
  endtask

  task automatic test_gaps();
    logic [15:0] words [4];
    logic [15:0] d;
    logic        r;
    logic        drop;
    words = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718};
    drop = 1'b0;
    pulse_load();
    send_byte(8'h00, $urandom_range(0, 3), r);
    send_byte(8'h04, $urandom_range(0, 3), r);
    for (int i = 0; i < 4; i++) begin
      send_byte(words[i][15:8], $urandom_range(0, 3), r);
      if (!r) drop = 1'b1;
      send_byte(words[i][7:0], $urandom_range(0, 3), r);
      if (!r) drop = 1'b1;
    end
    checks++; if (drop !== 1'b0) begin failures++; $display("FAIL gaps_ready_drop got=%b exp=0", drop); end
    checks++; if (loaded_words !== 16'd4 || cpu_en !== 1'b1 || overflow !== 1'b0) begin failures++; $display("FAIL gaps_done got words=%0d en=%b ovf=%b exp=4/1/0", loaded_words, cpu_en, overflow); end
    for (int i = 0; i < 4; i++) begin
      read_mem(16'(i), d);
      checks++; if (d !== words[i]) begin failures++; $display("FAIL gaps_mem%0d got=%h exp=%h", i, d, words[i]); end
    end
  endtask

  task automatic test_load_in_run();
    logic [15:0] d;
    logic        r;
    @(negedge clock);
    load_start = 1'b1;
    in_valid   = 1'b1;
    in_data    = 8'h00;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL lsr_ready got=%b exp=0", in_ready); end
    @(posedge clock);
    #1 load_start = 1'b0;
    in_valid = 1'b0;
    checks++; if (cpu_n_rst !== 1'b0 || cpu_en !== 1'b0 || loaded_words !== 16'd0) begin failures++; $display("FAIL lsr_restart got n_rst=%b en=%b words=%0d exp=0/0/0", cpu_n_rst, cpu_en, loaded_words); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL lsr_state got=%0d exp=0", dbg_state); end
    send_byte(8'h00, 0, r);
    send_byte(8'h01, 0, r);
    send_byte(8'hFF, 0, r);
    send_byte(8'hEE, 0, r);
    checks++; if (cpu_n_rst !== 1'b1 || loaded_words !== 16'd1) begin failures++; $display("FAIL lsr_reload got n_rst=%b words=%0d exp=1/1", cpu_n_rst, loaded_words); end
    read_mem(16'd0, d);
    checks++; if (d !== 16'hFFEE) begin failures++; $display("FAIL lsr_mem0 got=%h exp=ffee", d); end
    read_mem(16'd1, d);
    checks++; if (d !== 16'hC3D4) begin failures++; $display("FAIL lsr_mem1 got=%h exp=c3d4", d); end
  endtask

  task automatic test_rst_mid_load();
    logic [15:0] d;
    logic        r;
    pulse_load();
    send_byte(8'h00, 0, r);
    send_byte(8'h02, 0, r);
    send_byte(8'h12, 0, r);
    checks++; if (dbg_state !== 2'd2) begin failures++; $display("FAIL rml_in_data got=%0d exp=2", dbg_state); end
    #2 rst = 1'b1;
    imem_addr = 16'd0;
    #1;
    checks++; if (dbg_state !== 2'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL rml_async got state=%0d ready=%b exp=0/1", dbg_state, in_ready); end
    checks++; if (cpu_n_rst !== 1'b0 || cpu_en !== 1'b0 || loaded_words !== 16'd0 || overflow !== 1'b0 || imem_dout !== 16'h0) begin failures++; $display("FAIL rml_outputs got=%b%b/%h/%b/%h exp=00/0000/0/0000", cpu_n_rst, cpu_en, loaded_words, overflow, imem_dout); end
    @(negedge clock);
    rst = 1'b0;
    send_byte(8'h00, 0, r);
    send_byte(8'h01, 0, r);
    send_byte(8'h55, 0, r);
    send_byte(8'h66, 0, r);
    checks++; if (cpu_n_rst !== 1'b1 || loaded_words !== 16'd1) begin failures++; $display("FAIL rml_reload got n_rst=%b words=%0d exp=1/1", cpu_n_rst, loaded_words); end
    read_mem(16'd0, d);
    checks++; if (d !== 16'h5566) begin failures++; $display("FAIL rml_mem0 got=%h exp=5566", d); end
    read_mem(16'd1, d);
    checks++; if (d !== 16'hC3D4) begin failures++; $display("FAIL rml_mem1 got=%h exp=c3d4", d); end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_overflow();
    test_gaps();
    test_load_in_run();
    test_rst_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
